// File: rtl/zuc_pkg.sv
// Shared constants and helpers for the ZUC / EIA3 blocks.
package zuc_pkg;

  localparam int ZUC_WORD_W = 32;
  localparam int ZUC_BW     = 8;
  localparam int ZUC_KW     = 4;

  // n valid bytes -> MSB-aligned keep mask (n = 1..4; 0 gives an empty mask)
  function automatic logic [ZUC_KW-1:0] zuc_keep_mask(input logic [2:0] n);
    logic [ZUC_KW-1:0] mask;
    mask = '0;
    for (int i = 0; i < ZUC_KW; i++) begin
      if (i < int'(n)) mask[ZUC_KW-1-i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/zuc_regslice_chain.sv
// Chain of valid/ready register slices; each stage holds its word until popped.
module zuc_regslice_chain #(
  parameter int dw    = 32,
  parameter int depth = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [dw-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [dw-1:0] m_data
);

  logic [depth-1:0]         vld;
  logic [depth-1:0][dw-1:0] dat;
  logic [depth-1:0]         rdy;
  logic [depth-1:0]         in_v;
  logic [depth-1:0][dw-1:0] in_d;

  // A stage can accept when it is empty or its own word leaves this cycle
  always_comb begin
    logic r;
    r   = m_ready;
    rdy = '0;
    for (int i = depth - 1; i >= 0; i--) begin
      r      = !vld[i] || r;
      rdy[i] = r;
    end
  end

  always_comb begin
    in_v    = '0;
    in_d    = '0;
    in_v[0] = s_valid;
    in_d[0] = s_data;
    for (int i = 1; i < depth; i++) begin
      in_v[i] = vld[i-1];
      in_d[i] = dat[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      dat <= '0;
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (rdy[i]) begin
          vld[i] <= in_v[i];
          if (in_v[i]) dat[i] <= in_d[i];
        end
      end
    end
  end

  assign s_ready = rdy[0];
  assign m_valid = vld[depth-1];
  assign m_data  = dat[depth-1];

endmodule

// File: rtl/zuc_eia3_pack.sv
// Packs a byte stream MSB-first into 32-bit EIA3 words with keep mask,
// last flag and total message length.
module zuc_eia3_pack
  import zuc_pkg::*;
#(
  parameter int len_w = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ZUC_BW-1:0]     s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ZUC_WORD_W-1:0] m_data,
  output logic [ZUC_KW-1:0]     m_keep,
  output logic                  m_last,
  output logic [len_w-1:0]      m_len,
  output logic                  m_len_ovf
);

  localparam int DW = ZUC_WORD_W + ZUC_KW + 1 + len_w + 1;

  logic [23:0]           acc;
  logic [1:0]            idx;
  logic [len_w-1:0]      count;
  logic                  ovf;

  logic                  accept;
  logic                  word_done;
  logic                  sat;
  logic [len_w-1:0]      count_next;
  logic                  ovf_next;
  logic [ZUC_WORD_W-1:0] word;
  logic [ZUC_KW-1:0]     keep;
  logic [len_w-1:0]      len_fld;
  logic                  ovf_fld;
  logic [DW-1:0]         slice_in;
  logic [DW-1:0]         slice_out;

  assign accept     = s_valid && s_ready;
  assign word_done  = (idx == 2'd3) || s_last;
  assign sat        = &count;
  assign count_next = sat ? count : count + 1'b1;
  assign ovf_next   = ovf | sat;

  // Lanes above idx are still zero in acc, so unused lanes of a short last word stay 0
  always_comb begin
    word    = {acc, 8'h00} | ({24'h000000, s_data} << {~idx, 3'b000});
    keep    = zuc_keep_mask({1'b0, idx} + 3'd1);
    len_fld = s_last ? count_next : '0;
    ovf_fld = s_last & ovf_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      idx   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      if (word_done) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= word[31:8];
        idx <= idx + 2'd1;
      end
      if (s_last) begin
        count <= '0;
        ovf   <= 1'b0;
      end else begin
        count <= count_next;
        ovf   <= ovf_next;
      end
    end
  end

  assign slice_in = {word, keep, s_last, len_fld, ovf_fld};

  zuc_regslice_chain #(
    .dw    (DW),
    .depth (1)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .s_valid (accept && word_done),
    .s_ready (s_ready),
    .s_data  (slice_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (slice_out)
  );

  assign {m_data, m_keep, m_last, m_len, m_len_ovf} = slice_out;

endmodule
